// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C command arbiter: arbiter FSM state encoding,
// I2C address/data widths, and default watchdog limits.
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

  localparam int ADDR_W            = 7;
  localparam int DATA_W            = 8;
  localparam int DEF_START_TIMEOUT = 1024;
  localparam int DEF_DONE_TIMEOUT  = 65536;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// ---------------------------------------------------------------------------
// i2c_rr_pick
// Combinational round-robin selector. The search starts one past the last
// granted index and walks upward with wrap-around; the first pending request
// found wins.
//
// Ports:
//   i_req        [NUM_REQ-1:0]  pending request vector
//   i_last_grant [IDX_W-1:0]    index granted most recently
//   o_winner     [IDX_W-1:0]    selected index (0 when nothing pending)
//   o_any_valid                 at least one request pending
// ---------------------------------------------------------------------------
module i2c_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_valid
);

  logic             w_found;
  logic [IDX_W-1:0] w_winner;

  // Offsets 1..NUM_REQ from the last grant; the last grant itself is
  // examined last, so a lone requester can still win back-to-back.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && i_req[IDX_W'((int'(i_last_grant) + i) % NUM_REQ)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'((int'(i_last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign o_winner    = w_winner;
  assign o_any_valid = w_found;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_cmd_arbiter
// Shares one I2C byte master between NUM_REQ requesters. A round-robin winner
// is latched in IDLE, its command is presented to the master with
// m_dataValid until the master reports busy, and the result (or a watchdog
// abort) is returned as a one-cycle rsp_valid pulse to that requester.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/req_rw         per-requester command pending / 1=read
//   req_addr, req_din        packed 7-bit addresses / 8-bit write bytes
//   req_accept               one-cycle pulse: command captured
//   rsp_valid                one-cycle pulse: transaction finished
//   rsp_dout/ackErr/timeout  result, held between pulses
//   arb_busy                 FSM not idle
//   m_rw/m_addr/m_din/m_dataValid   command to master
//   m_dout/m_busy/m_ackErr/m_done   status from master
// ---------------------------------------------------------------------------
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]        req_accept,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_dout,
  output logic                      rsp_ackErr,
  output logic                      rsp_timeout,
  output logic                      arb_busy,
  output logic                      m_rw,
  output logic                      m_dataValid,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_din,
  input  logic [DATA_W-1:0]         m_dout,
  input  logic                      m_busy,
  input  logic                      m_ackErr,
  input  logic                      m_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // One counter serves both phases, so START_TIMEOUT must not exceed
  // DONE_TIMEOUT. Limits are last-count values: expiry happens after exactly
  // TIMEOUT cycles spent in the waiting state.
  localparam int                WD_W      = $clog2(DONE_TIMEOUT + 1);
  localparam logic [WD_W-1:0]   START_LIM = WD_W'(START_TIMEOUT - 1);
  localparam logic [WD_W-1:0]   DONE_LIM  = WD_W'(DONE_TIMEOUT - 1);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_last_grant;
  logic [WD_W-1:0]     r_wd;
  logic [NUM_REQ-1:0]  r_req_accept;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_dout;
  logic                r_rsp_ackErr;
  logic                r_rsp_timeout;
  logic                r_m_rw;
  logic                r_m_dataValid;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_din;

  logic [IDX_W-1:0]    w_winner;
  logic                w_any_valid;
  logic [WD_W-1:0]     w_wd_inc;
  logic [NUM_REQ-1:0]  w_win_onehot;
  logic [NUM_REQ-1:0]  w_grant_onehot;
  logic [ADDR_W-1:0]   w_addr [NUM_REQ];
  logic [DATA_W-1:0]   w_din  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_din[g]  = req_din[g*DATA_W +: DATA_W];
  end

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  // Saturating increment: the watchdog never wraps back to zero.
  assign w_wd_inc       = (&r_wd) ? r_wd : r_wd + WD_W'(1);
  assign w_win_onehot   = NUM_REQ'(1) << w_winner;
  assign w_grant_onehot = NUM_REQ'(1) << r_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_wd          <= '0;
      r_req_accept  <= '0;
      r_rsp_valid   <= '0;
      r_rsp_dout    <= '0;
      r_rsp_ackErr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_m_rw        <= 1'b0;
      r_m_dataValid <= 1'b0;
      r_m_addr      <= '0;
      r_m_din       <= '0;
    end else begin
      r_req_accept <= '0;
      r_rsp_valid  <= '0;
      case (r_state)
        S_IDLE: begin
          // Requests are only looked at here, so anything that appears and
          // vanishes while a transaction runs is never granted.
          if (w_any_valid && !m_busy) begin
            r_grant      <= w_winner;
            r_m_rw       <= req_rw[w_winner];
            r_m_addr     <= w_addr[w_winner];
            r_m_din      <= w_din[w_winner];
            r_req_accept <= w_win_onehot;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Registered, so m_dataValid rises the cycle after req_accept.
          r_m_dataValid <= 1'b1;
          r_wd          <= '0;
          r_state       <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (m_busy) begin
            r_m_dataValid <= 1'b0;
            r_wd          <= '0;
            r_state       <= S_WAIT_DONE;
          end else if (r_wd >= START_LIM) begin
            r_m_dataValid <= 1'b0;
            r_rsp_valid   <= w_grant_onehot;
            r_rsp_dout    <= '0;
            r_rsp_ackErr  <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_WAIT_DONE: begin
          // m_done is tested first so it beats a watchdog expiring in the
          // same cycle.
          if (m_done) begin
            r_rsp_valid   <= w_grant_onehot;
            r_rsp_dout    <= m_dout;
            r_rsp_ackErr  <= m_ackErr;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_wd >= DONE_LIM) begin
            r_m_dataValid <= 1'b0;
            r_rsp_valid   <= w_grant_onehot;
            r_rsp_dout    <= '0;
            r_rsp_ackErr  <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_RESP: begin
          // rsp_valid is high during this cycle; advance the round-robin
          // pointer only once the transaction is complete.
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: begin
          r_m_dataValid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign req_accept  = r_req_accept;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_dout    = r_rsp_dout;
  assign rsp_ackErr  = r_rsp_ackErr;
  assign rsp_timeout = r_rsp_timeout;
  assign arb_busy    = (r_state != S_IDLE);
  assign m_rw        = r_m_rw;
  assign m_dataValid = r_m_dataValid;
  assign m_addr      = r_m_addr;
  assign m_din       = r_m_din;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_arbiter
// Self-checking bench: a behavioural I2C master answers the arbiter, and a
// round-robin / timing reference model predicts grants, response cycles and
// response contents.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_arbiter;

  localparam int NR = 4;
  localparam int ST = 1024;
  localparam int DT = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_rw, req_accept, rsp_valid;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_din;
  logic [7:0]    rsp_dout, m_din, m_dout;
  logic          rsp_ackErr, rsp_timeout, arb_busy, m_rw, m_dataValid;
  logic [6:0]    m_addr;
  logic          m_busy, m_ackErr, m_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_last;

  // Results of the most recent transaction
  int t_acc_cyc, t_dv_first, t_dv_cnt, t_busy_cyc, t_done_cyc, t_rsp_cyc;
  logic [NR-1:0] t_acc_vec, t_rsp_vec;
  logic [7:0] t_rsp_dout, t_din;
  logic [6:0] t_addr;
  logic t_rsp_ack, t_rsp_to, t_got_rsp, t_unstable, t_rw;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_din(req_din), .req_accept(req_accept),
    .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .rsp_ackErr(rsp_ackErr),
    .rsp_timeout(rsp_timeout), .arb_busy(arb_busy), .m_rw(m_rw),
    .m_dataValid(m_dataValid), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout), .m_busy(m_busy), .m_ackErr(m_ackErr), .m_done(m_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Round-robin rule: first pending index after the last grant, with wrap.
  function automatic int rr_next(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic rand_cmds();
    req_rw   = NR'($urandom);
    req_addr = (7*NR)'($urandom);
    req_din  = $urandom;
  endtask

  // Behavioural master + monitor. busy_dly: m_busy rises on the busy_dly-th
  // cycle m_dataValid is seen high (0 = never). done_dly: m_done pulses
  // done_dly cycles after m_busy rose. Returns after the rsp_valid cycle.
  task automatic txn(input int busy_dly, input int done_dly,
                     input logic [7:0] dout, input logic ack);
    bit acc = 0, busy_set = 0, done_set = 0;
    t_acc_cyc = -1; t_dv_first = -1; t_dv_cnt = 0; t_busy_cyc = -1;
    t_done_cyc = -1; t_rsp_cyc = -1; t_got_rsp = 0; t_unstable = 0;
    t_acc_vec = '0; t_rsp_vec = '0;
    for (int n = 0; n < 6000; n++) begin
      step();
      m_dout = 8'($urandom);
      m_done = 1'b0;
      if (!acc && req_accept != '0) begin
        acc = 1; t_acc_cyc = cyc; t_acc_vec = req_accept;
        t_addr = m_addr; t_din = m_din; t_rw = m_rw;
      end else if (acc && (m_addr !== t_addr || m_din !== t_din || m_rw !== t_rw)) begin
        t_unstable = 1;
      end
      if (m_dataValid) begin
        t_dv_cnt++;
        if (t_dv_first < 0) t_dv_first = cyc;
      end
      if (rsp_valid != '0) begin
        t_got_rsp = 1; t_rsp_cyc = cyc; t_rsp_vec = rsp_valid;
        t_rsp_dout = rsp_dout; t_rsp_ack = rsp_ackErr; t_rsp_to = rsp_timeout;
        m_busy = 1'b0;
        break;
      end
      if (!busy_set && busy_dly > 0 && m_dataValid && t_dv_cnt == busy_dly) begin
        m_busy = 1'b1; busy_set = 1; t_busy_cyc = cyc;
      end else if (busy_set && !done_set && cyc == t_busy_cyc + done_dly) begin
        m_done = 1'b1; m_dout = dout; m_ackErr = ack; m_busy = 1'b0;
        done_set = 1; t_done_cyc = cyc;
      end
    end
    m_done = 1'b0;
    m_busy = 1'b0;
    checks++;
    if (!t_got_rsp) begin
      failures++;
      $display("FAIL txn_no_response got=none required=rsp_valid pulse");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; m_busy = 0; m_done = 0; m_ackErr = 0; m_dout = '0;
    rand_cmds();
    step(); step();
    checks++;
    if ({m_dataValid, m_rw, req_accept, rsp_valid, rsp_ackErr, rsp_timeout, arb_busy} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=0",
               {m_dataValid, m_rw, req_accept, rsp_valid, rsp_ackErr, rsp_timeout, arb_busy});
    end
    checks++;
    if ({m_addr, m_din, rsp_dout} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", {m_addr, m_din, rsp_dout});
    end
    rst = 1'b1;
    step(); step();
    checks++;
    if (arb_busy !== 1'b0 || req_accept !== '0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b acc=%b required 0/0", arb_busy, req_accept);
    end
    m_last = NR - 1;
  endtask

  task automatic test_single();
    int exp;
    logic [7:0] d;
    rand_cmds();
    req_rw[2] = 1'b0; req_addr[14 +: 7] = 7'h55; req_din[16 +: 8] = 8'h2F;
    req_valid = 4'b0100;
    exp = rr_next(m_last, req_valid);
    d = 8'($urandom);
    txn(3, 200, d, 1'b0);
    req_valid = '0;
    checks++; if (t_acc_vec !== NR'(1 << exp)) begin failures++; $display("FAIL single_accept got=%b required=%b", t_acc_vec, NR'(1 << exp)); end
    checks++; if (t_addr !== 7'h55) begin failures++; $display("FAIL single_addr got=%h required=55", t_addr); end
    checks++; if (t_din !== 8'h2F || t_rw !== 1'b0) begin failures++; $display("FAIL single_din_rw got=%h/%b required=2f/0", t_din, t_rw); end
    checks++; if (t_dv_first !== t_acc_cyc + 1) begin failures++; $display("FAIL single_dv_latency got=%0d required=%0d", t_dv_first, t_acc_cyc + 1); end
    checks++; if (t_dv_cnt !== 3) begin failures++; $display("FAIL single_dv_len got=%0d required=3", t_dv_cnt); end
    checks++; if (t_rsp_cyc !== t_done_cyc + 1) begin failures++; $display("FAIL single_rsp_latency got=%0d required=%0d", t_rsp_cyc, t_done_cyc + 1); end
    checks++; if (t_rsp_vec !== NR'(1 << exp)) begin failures++; $display("FAIL single_rsp_vec got=%b required=%b", t_rsp_vec, NR'(1 << exp)); end
    checks++; if ({t_rsp_dout, t_rsp_ack, t_rsp_to} !== {d, 2'b00}) begin failures++; $display("FAIL single_rsp_data got=%h/%b/%b required=%h/0/0", t_rsp_dout, t_rsp_ack, t_rsp_to, d); end
    checks++; if (t_unstable !== 1'b0) begin failures++; $display("FAIL single_cmd_stable got=unstable required=stable"); end
    m_last = exp;
  endtask

  task automatic test_round_robin();
    rst = 1'b0; step(); rst = 1'b1; m_last = NR - 1;
    rand_cmds();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp, bd, dd;
      logic [7:0] d;
      logic a;
      exp = rr_next(m_last, req_valid);
      bd = $urandom_range(1, 8); dd = $urandom_range(1, 30);
      d = 8'($urandom); a = 1'($urandom);
      txn(bd, dd, d, a);
      checks++; if (t_acc_vec !== NR'(1 << exp) || t_rsp_vec !== NR'(1 << exp)) begin failures++; $display("FAIL rr_grant%0d got=%b/%b required=%b", k, t_acc_vec, t_rsp_vec, NR'(1 << exp)); end
      checks++; if ({t_addr, t_din, t_rw} !== {req_addr[exp*7 +: 7], req_din[exp*8 +: 8], req_rw[exp]}) begin failures++; $display("FAIL rr_cmd%0d got=%h/%h/%b required=%h/%h/%b", k, t_addr, t_din, t_rw, req_addr[exp*7 +: 7], req_din[exp*8 +: 8], req_rw[exp]); end
      checks++; if ({t_rsp_dout, t_rsp_ack, t_rsp_to} !== {d, a, 1'b0} || t_rsp_cyc !== t_done_cyc + 1) begin failures++; $display("FAIL rr_rsp%0d got=%h/%b/%b@%0d required=%h/%b/0@%0d", k, t_rsp_dout, t_rsp_ack, t_rsp_to, t_rsp_cyc, d, a, t_done_cyc + 1); end
      m_last = exp;
    end
    req_valid = '0;
  endtask

  task automatic test_read_ackerr();
    int exp;
    rand_cmds();
    req_rw[1] = 1'b1;
    req_valid = 4'b0010;
    exp = rr_next(m_last, req_valid);
    txn($urandom_range(1, 6), $urandom_range(1, 50), 8'hA5, 1'b1);
    req_valid = '0;
    checks++; if (t_rsp_vec !== NR'(1 << exp) || t_rw !== 1'b1) begin failures++; $display("FAIL read_vec_rw got=%b/%b required=%b/1", t_rsp_vec, t_rw, NR'(1 << exp)); end
    checks++; if ({t_rsp_dout, t_rsp_ack, t_rsp_to} !== {8'hA5, 2'b10}) begin failures++; $display("FAIL read_rsp got=%h/%b/%b required=a5/1/0", t_rsp_dout, t_rsp_ack, t_rsp_to); end
    m_last = exp;
    for (int k = 0; k < 4; k++) step();
    checks++; if ({rsp_valid, rsp_dout, rsp_ackErr, rsp_timeout} !== {4'b0000, 8'hA5, 2'b10}) begin failures++; $display("FAIL read_hold got=%b/%h/%b/%b required=0/a5/1/0", rsp_valid, rsp_dout, rsp_ackErr, rsp_timeout); end
  endtask

  task automatic test_start_timeout();
    int r;
    r = $urandom_range(0, NR - 1);
    rand_cmds();
    req_valid = NR'(1 << r);
    txn(0, 1, 8'h00, 1'b0);
    req_valid = '0;
    checks++; if (t_rsp_vec !== NR'(1 << r)) begin failures++; $display("FAIL st_vec got=%b required=%b", t_rsp_vec, NR'(1 << r)); end
    checks++; if ({t_rsp_dout, t_rsp_ack, t_rsp_to} !== {8'h00, 2'b01}) begin failures++; $display("FAIL st_rsp got=%h/%b/%b required=00/0/1", t_rsp_dout, t_rsp_ack, t_rsp_to); end
    checks++; if (t_dv_cnt !== ST || t_rsp_cyc !== t_dv_first + ST) begin failures++; $display("FAIL st_timing got=dv%0d rsp@%0d required=dv%0d rsp@%0d", t_dv_cnt, t_rsp_cyc, ST, t_dv_first + ST); end
    m_last = r;
    step();
    checks++; if (arb_busy !== 1'b0 || m_dataValid !== 1'b0 || rsp_timeout !== 1'b1) begin failures++; $display("FAIL st_idle got=busy%b dv%b to%b required=0/0/1", arb_busy, m_dataValid, rsp_timeout); end
  endtask

  task automatic test_done_timeout();
    for (int k = 0; k < 2; k++) begin
      int r, dd, bd;
      logic [7:0] d;
      logic a, to;
      r = $urandom_range(0, NR - 1);
      rand_cmds();
      req_valid = NR'(1 << r);
      dd = DT + k; bd = $urandom_range(1, 5);
      d = 8'($urandom); a = 1'($urandom);
      to = (dd > DT);
      txn(bd, dd, d, a);
      req_valid = '0;
      checks++; if (t_rsp_to !== to || t_rsp_cyc !== t_busy_cyc + ((dd < DT) ? dd : DT) + 1) begin failures++; $display("FAIL dt%0d_timing got=to%b@%0d required=to%b@%0d", k, t_rsp_to, t_rsp_cyc, to, t_busy_cyc + ((dd < DT) ? dd : DT) + 1); end
      checks++; if ({t_rsp_dout, t_rsp_ack} !== (to ? 9'h000 : {d, a}) || t_rsp_vec !== NR'(1 << r)) begin failures++; $display("FAIL dt%0d_rsp got=%h/%b/%b required=%h/%b/%b", k, t_rsp_dout, t_rsp_ack, t_rsp_vec, to ? 8'h00 : d, to ? 1'b0 : a, NR'(1 << r)); end
      m_last = r;
    end
  endtask

  task automatic test_reset_mid();
    int r, bad;
    logic [7:0] d;
    logic a;
    r = $urandom_range(0, 2);
    rand_cmds();
    req_valid = NR'(1 << r);
    for (int n = 0; n < 20 && m_dataValid !== 1'b1; n++) step();
    m_busy = 1'b1;
    req_valid = '0;
    for (int n = 0; n < 5; n++) step();
    checks++; if (arb_busy !== 1'b1) begin failures++; $display("FAIL rm_in_txn got=busy%b required=1", arb_busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({m_dataValid, arb_busy} !== 2'b00) begin failures++; $display("FAIL rm_async got=%b required=00", {m_dataValid, arb_busy}); end
    m_busy = 1'b0;
    bad = 0;
    for (int n = 0; n < 3; n++) begin step(); if (rsp_valid != '0) bad++; end
    rst = 1'b1; m_last = NR - 1;
    for (int n = 0; n < 3; n++) begin step(); if (rsp_valid != '0) bad++; end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rm_no_rsp got=%0d pulses required=0", bad); end
    rand_cmds();
    req_valid = 4'b1000;
    d = 8'($urandom); a = 1'($urandom);
    txn($urandom_range(1, 5), $urandom_range(1, 20), d, a);
    req_valid = '0;
    checks++; if (t_acc_vec !== 4'b1000 || t_rsp_vec !== 4'b1000) begin failures++; $display("FAIL rm_regrant got=%b/%b required=1000", t_acc_vec, t_rsp_vec); end
    checks++; if ({t_addr, t_rsp_dout, t_rsp_ack, t_rsp_to} !== {req_addr[27:21], d, a, 1'b0}) begin failures++; $display("FAIL rm_rsp got=%h/%h/%b/%b required=%h/%h/%b/0", t_addr, t_rsp_dout, t_rsp_ack, t_rsp_to, req_addr[27:21], d, a); end
    m_last = 3;
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      int exp, bd, dd;
      logic [7:0] d;
      logic a;
      rand_cmds();
      req_valid = NR'($urandom_range(1, (1 << NR) - 1));
      exp = rr_next(m_last, req_valid);
      bd = $urandom_range(1, 10); dd = $urandom_range(1, 40);
      d = 8'($urandom); a = 1'($urandom);
      txn(bd, dd, d, a);
      checks++; if (t_acc_vec !== NR'(1 << exp) || t_rsp_vec !== NR'(1 << exp)) begin failures++; $display("FAIL rnd%0d_grant got=%b/%b required=%b", k, t_acc_vec, t_rsp_vec, NR'(1 << exp)); end
      checks++; if ({t_addr, t_din, t_rw, t_unstable} !== {req_addr[exp*7 +: 7], req_din[exp*8 +: 8], req_rw[exp], 1'b0}) begin failures++; $display("FAIL rnd%0d_cmd got=%h/%h/%b/%b required=%h/%h/%b/0", k, t_addr, t_din, t_rw, t_unstable, req_addr[exp*7 +: 7], req_din[exp*8 +: 8], req_rw[exp]); end
      checks++; if ({t_rsp_dout, t_rsp_ack, t_rsp_to} !== {d, a, 1'b0} || t_rsp_cyc !== t_done_cyc + 1 || t_dv_cnt !== bd) begin failures++; $display("FAIL rnd%0d_rsp got=%h/%b/%b@%0d dv%0d required=%h/%b/0@%0d dv%0d", k, t_rsp_dout, t_rsp_ack, t_rsp_to, t_rsp_cyc, t_dv_cnt, d, a, t_done_cyc + 1, bd); end
      m_last = exp;
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; m_busy = 0; m_done = 0; m_ackErr = 0; m_dout = '0;
    rand_cmds();
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_read_ackerr();
    test_start_timeout();
    test_done_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit got=still running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
